// File: rtl/multicycle_control_fsm_pkg.sv
// ctrl_pkg: state encodings, opcode and ALU-op constants for the multicycle RV32I sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OPIMM,
        CLS_OP
    } cls_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // alt selects SUB/SRA over ADD/SRL; callers decide when funct7[5] is meaningful
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_code = ALU_SLL;
            3'b010:  alu_code = ALU_SLT;
            3'b011:  alu_code = ALU_SLTU;
            3'b100:  alu_code = ALU_XOR;
            3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_code = ALU_OR;
            default: alu_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// alu_op_decoder: classifies an RV32I word, checks legality and picks the ALU op and branch polarity.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  alu_op,
    output logic        legal,
    output cls_t        cls,
    output logic        br_inv
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign unused_bits = ^{inst[24:15], inst[11:7]};

    // BNE/BLT/BLTU are taken on a non-zero ALU result, the rest on zero
    assign br_inv = f3[0] ^ f3[2];

    always_comb begin
        cls    = CLS_NONE;
        legal  = 1'b0;
        alu_op = ALU_ADD;
        case (opc)
            OPC_BRANCH: begin
                cls    = CLS_BRANCH;
                legal  = f3[2:1] != 2'b01;
                alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_LOAD: begin
                cls   = CLS_LOAD;
                legal = f3 == 3'b010;
            end
            OPC_STORE: begin
                cls   = CLS_STORE;
                legal = f3 == 3'b010;
            end
            OPC_OPIMM: begin
                cls    = CLS_OPIMM;
                legal  = f3 == 3'b001 ? f7 == F7_ZERO :
                         f3 == 3'b101 ? (f7 == F7_ZERO || f7 == F7_ALT) : 1'b1;
                alu_op = alu_code(f3, f3 == 3'b101 && f7[5]);
            end
            OPC_OP: begin
                cls    = CLS_OP;
                legal  = f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                alu_op = alu_code(f3, f7[5]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with req/ack memory timeouts.
// Define MULTICYCLE_PERF_EN to add cycle_cnt_o/instret_cnt_o performance counters.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] Inst_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    input  logic        alu_zero_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_src_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        alu_src_o,
    output logic [3:0]  alu_op_o,
    output logic        reg_we_o,
    output logic        mem_to_reg_o,
    output logic        illegal_o,
    output logic        timeout_o,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o,
    output logic [2:0]  state_o
`else
    output logic [2:0]  state_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       alu_op;
    logic             legal;
    cls_t             cls;
    logic             br_inv;
    logic             is_mem;

    alu_op_decoder u_dec (
        .inst   (Inst_i),
        .alu_op (alu_op),
        .legal  (legal),
        .cls    (cls),
        .br_inv (br_inv)
    );

    assign is_mem = cls == CLS_LOAD || cls == CLS_STORE;

    assign state_o      = state;
    assign imem_req_o   = state == S_FETCH;
    assign ir_we_o      = state == S_FETCH && imem_ack_i;
    assign dmem_req_o   = state == S_MEM;
    assign dmem_we_o    = state == S_MEM && cls == CLS_STORE;
    assign alu_op_o     = state == S_EXEC ? alu_op : ALU_ADD;
    assign alu_src_o    = state == S_EXEC && (is_mem || cls == CLS_OPIMM);
    assign pc_src_o     = state == S_EXEC && cls == CLS_BRANCH && (alu_zero_i ^ br_inv);
    assign reg_we_o     = state == S_WB;
    assign mem_to_reg_o = state == S_WB && cls == CLS_LOAD;
    assign pc_we_o      = (state == S_EXEC && cls == CLS_BRANCH) ||
                          (state == S_MEM && cls == CLS_STORE && dmem_ack_i) ||
                          state == S_WB;

    // cnt defaults to 0 so it is already clear on every entry to FETCH and MEM
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            illegal_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            cnt <= '0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH, S_MEM: begin
                    if (state == S_FETCH ? imem_ack_i : dmem_ack_i) begin
                        if (state == S_FETCH)
                            state <= S_DECODE;
                        else if (cls == CLS_STORE)
                            state <= S_FETCH;
                        else
                            state <= S_WB;
                    end else if (cnt == CNT_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        illegal_o <= 1'b1;
                        state     <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (cls == CLS_BRANCH)
                        state <= S_FETCH;
                    else if (is_mem)
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_TRAP;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP)
                cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (pc_we_o)
                instret_cnt_o <= instret_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I integer datapath. It replaces single-cycle combinational control with a Moore/Mealy FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- It sits between the instruction register, the ALU/register file and the two memory ports.
- It handles variable-latency instruction and data memories through req/ack handshakes.
- It flags illegal encodings and memory timeouts.

Parameters:
- WAIT_MAX, 15: maximum cycles an imem/dmem request may wait for ack before trapping. Minimum legal value is 1.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- Inst_i  in  32  instruction register contents, valid from DECODE onward.
- imem_ack_i  in  1  instruction memory has delivered the word; IR captures it this cycle.
- dmem_ack_i  in  1  data memory access completed.
- alu_zero_i  in  1  ALU result == 0.
- imem_req_o  out  1  instruction fetch request.
- ir_we_o  out  1  instruction register load strobe.
- pc_we_o  out  1  PC update strobe.
- pc_src_o  out  1  0 = PC+4, 1 = branch target.
- dmem_req_o  out  1  data memory request.
- dmem_we_o  out  1  data memory write (store).
- alu_src_o  out  1  0 = rs2, 1 = immediate.
- alu_op_o  out  4  ALU operation code.
- reg_we_o  out  1  register file write strobe.
- mem_to_reg_o  out  1  write-back source = load data.
- illegal_o  out  1  sticky: illegal instruction trapped.
- timeout_o  out  1  sticky: memory handshake timeout trapped.
- state_o  out  3  current state encoding, for debug.

Behaviour:
Reset:
- Asynchronous reset forces state = IDLE, wait counter = 0, and all outputs to 0, including the sticky flags.
- Reset mid-instruction abandons the instruction with no PC or register writes.

State transitions:
- IDLE: always moves to FETCH on the next cycle.
- FETCH:
  - imem_req_o = 1.
  - On imem_ack_i: ir_we_o = 1 in that same cycle, go to DECODE.
  - Otherwise increment the wait counter. When it reaches WAIT_MAX, set timeout_o and go to TRAP.
- DECODE:
  - Classify opcode Inst_i[6:0]: 1100011 branch, 0000011 load, 0100011 store, 0010011 OP-IMM, 0110011 OP.
  - Legality rules:
    - Load and store require funct3 = 010.
    - Branch funct3 010 and 011 are illegal.
    - OP: funct7 must be 0000000, or 0100000 with funct3 000 or 101.
    - OP-IMM funct3 001: funct7 must be 0000000.
    - OP-IMM funct3 101: funct7 must be 0000000 or 0100000.
  - Illegal instruction: set illegal_o, go to TRAP. Legal instruction: go to EXEC.
- EXEC: alu_op_o and alu_src_o are valid (alu_src_o = 1 for load, store and OP-IMM).
  - Branch: pc_we_o = 1 and pc_src_o = taken, then go to FETCH.
    - taken = alu_zero_i for BEQ, BGE, BGEU.
    - taken = ~alu_zero_i for BNE, BLT, BLTU.
  - Load or store: go to MEM.
  - OP or OP-IMM: go to WB.
- MEM:
  - dmem_req_o = 1; dmem_we_o = 1 for store.
  - The wait counter works as in FETCH.
  - On dmem_ack_i: store sets pc_we_o = 1 with pc_src_o = 0 and goes to FETCH; load goes to WB.
- WB:
  - reg_we_o = 1; mem_to_reg_o = 1 for load.
  - pc_we_o = 1 with pc_src_o = 0, then go to FETCH.
- TRAP: absorbing. All strobes are 0 and the sticky flags hold. Only reset exits.

Wait counter:
- Clears on entry to FETCH and to MEM.
- A request asserted with an immediate ack costs zero wait cycles.

Latency with zero-wait memories:
- Branch: 3 cycles.
- OP, OP-IMM, store: 4 cycles.
- Load: 5 cycles.

ALU codes, indexed by {funct7[5], funct3}:
- ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- OP-IMM funct3 000 always produces ADD; funct7[5] is part of the immediate and is ignored.
- Load and store produce ADD.
- Branches: BEQ/BNE → SUB, BLT/BGE → SLT, BLTU/BGEU → SLTU.

Output timing:
- Strobes are combinational from state and inputs.
- Each strobe is asserted for exactly one cycle per instruction.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined, adds two 32-bit outputs:
  - cycle_cnt_o: increments every cycle outside IDLE and TRAP.
  - instret_cnt_o: increments on every pc_we_o.
- Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters do not exist.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings (IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6);
  - opcode constants;
  - ALU op constants.
- One combinational sub-module, alu_op_decoder: takes Inst_i and produces alu_op, the legal flag, the instruction class and the branch-polarity bit.
- The FSM, wait counter and perf counters stay in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), zero-wait memories → state sequence 1,2,3,5,1; alu_op_o = 0; reg_we_o and pc_we_o (pc_src_o = 0) pulse in WB.
- LW (0x0000A183), dmem_ack_i delayed 3 cycles → dmem_req_o high for 4 cycles, then WB with mem_to_reg_o = 1; total 8 cycles.
- BNE (0x00209463): alu_zero_i = 0 → pc_src_o = 1 in EXEC; alu_zero_i = 1 → pc_src_o = 0; alu_op_o = 1 in both cases.
- Illegal SUB variant with funct7 = 0100000 and funct3 = 001 (0x402091B3) → illegal_o = 1, state_o = 6, no reg_we_o or pc_we_o, stays put for 20 cycles.
- imem_ack_i held low with WAIT_MAX = 15 → timeout_o set after 15 wait cycles, TRAP entered.
- rst_n_i pulsed low during MEM of a store → dmem_req_o drops immediately, state_o = 0, next cycle FETCH with no pc_we_o.
